chip_sp_msg_checker: RTL and testbench
======================================

CHIP_SP_MSG_CHECKER -- requirements
Module: chip_sp_msg_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 2: number of back-to-back complete words of one message required to enter lock (legal 1..7).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 d_in  input  8  ASCII byte from the message generator.
REQ-005 valid  input  1  d_in sampled only when high; low = stall.
REQ-006 found  output  1  one-cycle pulse: a complete message word was just recognised.
REQ-007 found_id  output  1  message of the last found pulse: 0 = "Guatemala", 1 = "QQuetza".
REQ-008 locked  output  1  high while in a LOCKED state.
REQ-009 lock_id  output  1  message locked to (0 = A, 1 = B); 0 when unlocked.
REQ-010 word_cnt  output  8  complete words recognised while locked.
REQ-011 err_cnt  output  8  lock losses since reset.

Function
REQ-012 Pattern A SHALL be the 9 bytes 0x47 0x75 0x61 0x74 0x65 0x6D 0x61 0x6C 0x61; pattern B the 7 bytes 0x51 0x51 0x75 0x65 0x74 0x7A 0x61.
REQ-013 Two independent matchers (idx_a 0..8, idx_b 0..6) SHALL evaluate every valid byte in parallel.
REQ-014 Matching byte: idx advances by 1; matching byte at last index: completion, idx returns to 0.
REQ-015 Mismatch fallback: idx <= 1 if byte equals pattern[0], else 0; exception for B: mismatch at idx_b=2 with byte 0x51 keeps idx_b=2.
REQ-016 Each matcher SHALL keep a run counter (3 bits): incremented on completion, cleared on any mismatch; the next byte after a completion that equals pattern[0] keeps the run.
REQ-017 found SHALL assert the cycle after the final byte of a word is sampled, with found_id set; if both completions coincide, A has priority.
REQ-018 FSM states HUNT, LOCKED_A, LOCKED_B; reset state HUNT.
REQ-019 HUNT -> LOCKED_x when run counter of x reaches LOCK_COUNT; locked/lock_id update in the same cycle as the corresponding found pulse; A wins ties.
REQ-020 In LOCKED_x, every valid byte is compared with pattern_x[idx_x]; a mismatch returns the FSM to HUNT, increments err_cnt, clears both run counters; the mismatching byte still drives the fallback of REQ-015.
REQ-021 In LOCKED_x, each completion of x increments word_cnt, wrapping 255 -> 0; word_cnt cleared on entry to LOCKED_x and unchanged in HUNT.
REQ-022 err_cnt SHALL saturate at 255.
REQ-023 valid low: all state held, found low, no counter changes.
REQ-024 All outputs registered; latency from sampled byte to any output effect is exactly 1 cycle.

Reset
REQ-025 reset high at a clock edge SHALL force HUNT, idx_a=idx_b=0, run counters 0, found=0, found_id=0, locked=0, lock_id=0, word_cnt=0, err_cnt=0.
REQ-026 reset SHALL take priority over valid and over any completion or mismatch in the same cycle, including mid-word and while locked.

Verification
REQ-027 Stream "GuatemalaGuatemala" continuous valid -> found pulses after byte 9 and 18, found_id=0; locked=1, lock_id=0 with the second pulse; word_cnt=0 then counting from the third word.
REQ-028 Stream "QQuetzaQQuetza" -> lock to B after byte 14; then "QQQuetza" inserted -> mismatch-free only via REQ-015 exception? No: byte 3 (0x51 at idx 2) causes lock loss, err_cnt=1, idx_b=2, word still completes, found pulses with found_id=1.
REQ-029 Locked to A, byte 0x6C replaced by 0x00 -> locked=0 next cycle, err_cnt=1, word_cnt held, no found for that word.
REQ-030 Locked stream with valid toggling every other cycle -> same found/word_cnt sequence as continuous stream, only stretched; no spurious pulses.
REQ-031 Assert reset during byte 5 of a locked word -> all outputs zero next cycle; resumed stream relocks after LOCK_COUNT full words.
REQ-032 Force 260 lock losses -> err_cnt stops at 255; 300 locked words -> word_cnt = 44.

Source files
------------

// File: rtl/chip_sp_msg_checker.sv
// chip_sp_msg_checker: recognises the message words "Guatemala" (A) and
// "QQuetza" (B) in a byte stream, locks onto a repeating word and counts
// recognised words and lock losses.
module chip_sp_msg_checker #(
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] d_in,
    input  logic       valid,
    output logic       found,
    output logic       found_id,
    output logic       locked,
    output logic       lock_id,
    output logic [7:0] word_cnt,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, LOCKED_A, LOCKED_B} state_t;

    localparam logic [2:0] LOCK_RUN = 3'(LOCK_COUNT);

    function automatic logic [7:0] pat_a(input logic [3:0] i);
        case (i)
            4'd0:    pat_a = 8'h47;
            4'd1:    pat_a = 8'h75;
            4'd2:    pat_a = 8'h61;
            4'd3:    pat_a = 8'h74;
            4'd4:    pat_a = 8'h65;
            4'd5:    pat_a = 8'h6D;
            4'd6:    pat_a = 8'h61;
            4'd7:    pat_a = 8'h6C;
            4'd8:    pat_a = 8'h61;
            default: pat_a = '0;
        endcase
    endfunction

    function automatic logic [7:0] pat_b(input logic [2:0] i);
        case (i)
            3'd0:    pat_b = 8'h51;
            3'd1:    pat_b = 8'h51;
            3'd2:    pat_b = 8'h75;
            3'd3:    pat_b = 8'h65;
            3'd4:    pat_b = 8'h74;
            3'd5:    pat_b = 8'h7A;
            3'd6:    pat_b = 8'h61;
            default: pat_b = '0;
        endcase
    endfunction

    state_t     state_q;
    logic [3:0] idx_a_q, idx_a_d;
    logic [2:0] idx_b_q, idx_b_d;
    logic [2:0] run_a_q, run_a_d;
    logic [2:0] run_b_q, run_b_d;
    logic       hit_a, done_a, hit_b, done_b;
    logic       found_q, found_id_q, locked_q, lock_id_q;
    logic [7:0] word_cnt_q, err_cnt_q;

    // Both matchers evaluate the current byte in parallel.
    always_comb begin
        hit_a  = (d_in == pat_a(idx_a_q));
        done_a = hit_a && (idx_a_q == 4'd8);
        if (hit_a) begin
            idx_a_d = done_a ? 4'd0 : idx_a_q + 4'd1;
        end else begin
            idx_a_d = (d_in == pat_a(4'd0)) ? 4'd1 : 4'd0;
        end
        run_a_d = run_a_q;
        if (!hit_a) begin
            run_a_d = '0;
        end else if (done_a && run_a_q != 3'd7) begin
            run_a_d = run_a_q + 3'd1;
        end

        hit_b  = (d_in == pat_b(idx_b_q));
        done_b = hit_b && (idx_b_q == 3'd6);
        if (hit_b) begin
            idx_b_d = done_b ? 3'd0 : idx_b_q + 3'd1;
        end else if (idx_b_q == 3'd2 && d_in == 8'h51) begin
            // "QQQ...": the surplus Q still leaves a valid "QQ" prefix.
            idx_b_d = 3'd2;
        end else begin
            idx_b_d = (d_in == pat_b(3'd0)) ? 3'd1 : 3'd0;
        end
        run_b_d = run_b_q;
        if (!hit_b) begin
            run_b_d = '0;
        end else if (done_b && run_b_q != 3'd7) begin
            run_b_d = run_b_q + 3'd1;
        end
    end

    // Lock FSM, matcher state and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            idx_a_q    <= '0;
            idx_b_q    <= '0;
            run_a_q    <= '0;
            run_b_q    <= '0;
            found_q    <= 1'b0;
            found_id_q <= 1'b0;
            locked_q   <= 1'b0;
            lock_id_q  <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (valid) begin
            idx_a_q <= idx_a_d;
            idx_b_q <= idx_b_d;
            run_a_q <= run_a_d;
            run_b_q <= run_b_d;
            found_q <= done_a | done_b;
            if (done_a | done_b) begin
                found_id_q <= ~done_a;
            end
            case (state_q)
                HUNT: begin
                    if (done_a && run_a_d >= LOCK_RUN) begin
                        state_q    <= LOCKED_A;
                        locked_q   <= 1'b1;
                        lock_id_q  <= 1'b0;
                        word_cnt_q <= '0;
                    end else if (done_b && run_b_d >= LOCK_RUN) begin
                        state_q    <= LOCKED_B;
                        locked_q   <= 1'b1;
                        lock_id_q  <= 1'b1;
                        word_cnt_q <= '0;
                    end
                end
                LOCKED_A, LOCKED_B: begin
                    if ((state_q == LOCKED_A) ? !hit_a : !hit_b) begin
                        state_q   <= HUNT;
                        locked_q  <= 1'b0;
                        lock_id_q <= 1'b0;
                        run_a_q   <= '0;
                        run_b_q   <= '0;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end else if ((state_q == LOCKED_A) ? done_a : done_b) begin
                        word_cnt_q <= word_cnt_q + 8'd1;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end else begin
            found_q <= 1'b0;
        end
    end

    assign found    = found_q;
    assign found_id = found_id_q;
    assign locked   = locked_q;
    assign lock_id  = lock_id_q;
    assign word_cnt = word_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_chip_sp_msg_checker.sv
// Scoreboard bench for chip_sp_msg_checker: a reference model predicts the
// outputs for every driven cycle; the monitor compares them after each edge.
module tb_chip_sp_msg_checker;

    localparam int LC = 2;

    logic       clk;
    logic       reset;
    logic [7:0] d_in;
    logic       valid;
    logic       found, found_id, locked, lock_id;
    logic [7:0] word_cnt, err_cnt;

    chip_sp_msg_checker #(.LOCK_COUNT(LC)) dut (
        .clk     (clk),
        .reset   (reset),
        .d_in    (d_in),
        .valid   (valid),
        .found   (found),
        .found_id(found_id),
        .locked  (locked),
        .lock_id (lock_id),
        .word_cnt(word_cnt),
        .err_cnt (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       f;
        logic       fid;
        logic       lk;
        logic       lid;
        logic [7:0] wc;
        logic [7:0] ec;
    } exp_t;

    exp_t sb[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] PA [0:8] = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
    logic [7:0] PB [0:6] = '{8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};

    int m_ia, m_ib, m_ra, m_rb, m_st, m_wc, m_ec;
    bit m_f, m_fid, m_lk, m_lid;

    task automatic model_step(input bit r, input bit v, input logic [7:0] b);
        exp_t e;
        bit ca, cb, ma, mb;
        if (r) begin
            m_ia = 0; m_ib = 0; m_ra = 0; m_rb = 0; m_st = 0;
            m_wc = 0; m_ec = 0; m_f = 0; m_fid = 0; m_lk = 0; m_lid = 0;
        end else if (!v) begin
            m_f = 0;
        end else begin
            ma = (b != PA[m_ia]);
            mb = (b != PB[m_ib]);
            ca = !ma && (m_ia == 8);
            cb = !mb && (m_ib == 6);
            if (!ma) m_ia = ca ? 0 : m_ia + 1;
            else     m_ia = (b == PA[0]) ? 1 : 0;
            if (!mb)                         m_ib = cb ? 0 : m_ib + 1;
            else if (m_ib == 2 && b == 8'h51) m_ib = 2;
            else                             m_ib = (b == PB[0]) ? 1 : 0;
            m_ra = ma ? 0 : (ca ? ((m_ra < 7) ? m_ra + 1 : 7) : m_ra);
            m_rb = mb ? 0 : (cb ? ((m_rb < 7) ? m_rb + 1 : 7) : m_rb);
            m_f = ca | cb;
            if (m_f) m_fid = !ca;
            if (m_st == 0) begin
                if (ca && m_ra >= LC)      begin m_st = 1; m_wc = 0; end
                else if (cb && m_rb >= LC) begin m_st = 2; m_wc = 0; end
            end else if ((m_st == 1 && ma) || (m_st == 2 && mb)) begin
                m_st = 0; m_ra = 0; m_rb = 0;
                if (m_ec < 255) m_ec++;
            end else if ((m_st == 1 && ca) || (m_st == 2 && cb)) begin
                m_wc = (m_wc + 1) % 256;
            end
            m_lk  = (m_st != 0);
            m_lid = (m_st == 2);
        end
        e.f = m_f; e.fid = m_fid; e.lk = m_lk; e.lid = m_lid;
        e.wc = 8'(m_wc); e.ec = 8'(m_ec);
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("found",    found,    e.f);
            chk("found_id", found_id, e.fid);
            chk("locked",   locked,   e.lk);
            chk("lock_id",  lock_id,  e.lid);
            chk("word_cnt", word_cnt, e.wc);
            chk("err_cnt",  err_cnt,  e.ec);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc(input bit r, input bit v, input logic [7:0] b);
        @(negedge clk);
        reset = r; valid = v; d_in = b;
        model_step(r, v, b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) cyc(1'b0, 1'b1, s[i]);
    endtask

    task automatic send_gap(input string s);
        for (int i = 0; i < s.len(); i++) begin
            cyc(1'b0, 1'b1, s[i]);
            cyc(1'b0, 1'b0, 8'($urandom));
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h47);
    endtask

    // Let the last driven byte reach the outputs before a direct check.
    task automatic probe();
        @(posedge clk);
        #2;
    endtask

    string alpha;
    logic [7:0] rb;

    initial begin
        reset = 1'b1; valid = 1'b0; d_in = '0;
        alpha = "GuatemlQz";

        // reset state
        do_reset();
        probe();
        chk("rst_found",  found,    0);
        chk("rst_locked", locked,   0);
        chk("rst_wc",     word_cnt, 0);
        chk("rst_ec",     err_cnt,  0);

        // two words of A lock; counting starts with the third word
        send_str("Guatemal"); cyc(1'b0, 1'b1, "a"); probe();
        chk("a1_found", found, 1); chk("a1_fid", found_id, 0); chk("a1_locked", locked, 0);
        send_str("Guatemal"); cyc(1'b0, 1'b1, "a"); probe();
        chk("a2_found", found, 1); chk("a2_locked", locked, 1);
        chk("a2_lockid", lock_id, 0); chk("a2_wc", word_cnt, 0);
        send_str("Guatemal"); cyc(1'b0, 1'b1, "a"); probe();
        chk("a3_wc", word_cnt, 1);

        // lock to B, then "QQQuetza" loses lock but still completes
        do_reset();
        send_str("QQuetzaQQuetz"); cyc(1'b0, 1'b1, "a"); probe();
        chk("b_locked", locked, 1); chk("b_lockid", lock_id, 1);
        send_str("QQ"); cyc(1'b0, 1'b1, "Q"); probe();
        chk("bq_locked", locked, 0); chk("bq_ec", err_cnt, 1);
        send_str("uetz"); cyc(1'b0, 1'b1, "a"); probe();
        chk("bq_found", found, 1); chk("bq_fid", found_id, 1); chk("bq_locked2", locked, 0);

        // corrupted byte inside a locked A word
        do_reset();
        send_str("GuatemalaGuatemalaGuatemalaGuatema");
        cyc(1'b0, 1'b1, 8'h00); probe();
        chk("c_locked", locked, 0); chk("c_ec", err_cnt, 1); chk("c_wc", word_cnt, 1);
        cyc(1'b0, 1'b1, "a"); probe();
        chk("c_nofound", found, 0);

        // valid toggling: stretched but identical sequence
        do_reset();
        send_gap("GuatemalaGuatemalaGuatemala");
        probe();
        chk("g_locked", locked, 1); chk("g_wc", word_cnt, 1);

        // reset in the middle of a locked word, then relock
        send_str("Guat");
        cyc(1'b1, 1'b1, "e"); probe();
        chk("mr_found", found, 0); chk("mr_locked", locked, 0);
        chk("mr_wc", word_cnt, 0); chk("mr_fid", found_id, 0);
        send_str("Guatemala"); probe();
        chk("mr_locked1", locked, 0);
        send_str("Guatemala"); probe();
        chk("mr_relock", locked, 1);

        // mixed noise from the pattern alphabet
        for (int i = 0; i < 400; i++) begin
            rb = ($urandom_range(0, 7) == 0) ? 8'($urandom) : alpha[$urandom_range(0, 8)];
            cyc(1'b0, ($urandom_range(0, 3) != 0), rb);
        end
        send_str("QQuetzaQQuetzaQQuetzaGuatemala");

        // saturating error counter and wrapping word counter
        do_reset();
        for (int i = 0; i < 260; i++) begin
            send_str("GuatemalaGuatemala");
            cyc(1'b0, 1'b1, 8'h00);
        end
        for (int i = 0; i < 302; i++) send_str("Guatemala");
        probe();
        chk("sat_ec", err_cnt, 255);
        chk("wrap_wc", word_cnt, 44);

        cyc(1'b0, 1'b0, 8'h00);
        probe();
        chk("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
